jump_motion_ctrl: RTL and testbench
===================================

Name: jump_motion_ctrl

Overview:
Per-frame motion sequencer for the player ball. It decodes keyboard keycodes and runs a jump state machine: ground, rise, apex hold, fall. It drives signed X/Y motion values into the ball position datapath, which computes pos_next = pos + motion on the same frame_clk edge. Landing and wall stops are exact, with no overshoot, because the block predicts the datapath's next position.

Parameters:
X_MIN, 0, leftmost pixel; the ball's left edge (ball_x - ball_s) must not go below it
X_MAX, 639, rightmost pixel; ball_x + ball_s must not exceed it
Y_MAX, 479, floor; ball rests with ball_y + ball_s == Y_MAX
STEP, 1, pixels per frame for walk, rise and fall
JUMP_HEIGHT, 100, rise distance in pixels above the takeoff y
APEX_FRAMES, 4, frames held at apex with motion_y = 0; must be >= 1
KEY_UP, 16'h001A, jump keycode (W)
KEY_LEFT, 16'h0004, left keycode (A)
KEY_RIGHT, 16'h0007, right keycode (D)

Ports:
frame_clk  in  1  frame clock, ~60 Hz
Reset  in  1  async active-high reset
key  in  16  current keycode; 0 = none
ball_x  in  10  current ball centre X, from datapath register
ball_y  in  10  current ball centre Y
ball_s  in  10  ball half-size
motion_x  out  10  two's-complement X motion, registered
motion_y  out  10  two's-complement Y motion, registered
jstate  out  2  state: 0 GROUND, 1 RISE, 2 APEX, 3 FALL
airborne  out  1  high when jstate != GROUND

Behaviour:
- Reset is asynchronous, active-high; the clock is frame_clk. All state updates on posedge frame_clk.
- Reset values: motion_x = 0, motion_y = 0, jstate = FALL, airborne = 1, prev_key = 0, apex_cnt = 0, top = 0. FALL at reset makes a mid-air ball drop to the floor.
- Internal arithmetic is 11-bit signed; no unsigned subtraction may wrap.
- Predicted position (position after the current edge): px = ball_x + motion_x, py = ball_y + motion_y.
- Jump edge: key == KEY_UP and prev_key != KEY_UP. prev_key <= key every edge.
- Horizontal control (all states):
  - KEY_LEFT: motion_x <= -min(STEP, px - ball_s - X_MIN), floored at 0.
  - KEY_RIGHT: motion_x <= +min(STEP, X_MAX - ball_s - px), floored at 0.
  - Otherwise: motion_x <= 0.
- GROUND:
  - motion_y <= 0.
  - On jump edge: top <= max(py - JUMP_HEIGHT, ball_s); jstate <= RISE; motion_y <= -min(STEP, py - top_new).
- RISE:
  - If py - STEP <= top: motion_y <= top - py (0 or negative); jstate <= APEX; apex_cnt <= APEX_FRAMES - 1.
  - Else: motion_y <= -STEP.
- APEX:
  - motion_y <= 0; apex_cnt decrements each edge.
  - On the edge where apex_cnt == 0: jstate <= FALL; motion_y <= +STEP.
  - Net effect: exactly APEX_FRAMES frames with zero Y motion.
- FALL:
  - If py + ball_s + STEP >= Y_MAX: motion_y <= max(Y_MAX - ball_s - py, 0); jstate <= GROUND.
  - Else: motion_y <= +STEP.
- Jump edge outside GROUND is ignored (no double jump).
- A held KEY_UP never retriggers; the key must be released before the next jump.
- A keycode change mid-air affects only motion_x.
- Latency: a key change appears on motion_* one edge later; the position reflects it on the following edge.
- Reset asserted mid-operation immediately returns all outputs to reset values.

Test Plan:
The bench integrates pos += motion on each edge. ball_s = 4; start (320,240).
1. Reset, key = 0 -> first edge motion_y = 1, jstate = FALL. After 235 frames ball_y = 475, motion_y = 0, jstate = GROUND, no overshoot to 476.
2. On ground at y = 475, key = 16'h001A one frame -> next edge jstate = RISE, motion_y = 10'h3FF. Ball reaches y = 375 exactly; 4 frames APEX with motion_y = 0; then FALL, landing at y = 475.
3. Hold 16'h001A continuously through landing -> exactly one jump; jstate stays GROUND after landing until the key is released and re-pressed.
4. ball_x = 6, hold 16'h0004 -> ball_x goes 5, 4, then motion_x = 0 and ball_x stays 4. Mirror case: ball_x = 633 with 16'h0007 stops at 635.
5. Takeoff at y = 50 -> top clamped to 4; the ball stops at y = 4 without wrapping below 0.
6. Assert Reset during RISE at y = 420 -> outputs are 0 and jstate = FALL immediately, without waiting for a clock edge. After release, the ball falls back to 475.

Source files
------------

// File: rtl/jump_motion_if.sv
// Ball motion bus: keyboard/position inputs and per-frame motion outputs.
// master drives key and ball state, slave produces motion and jump state.
interface jump_motion_if;
    logic [15:0] key;
    logic [9:0]  ball_x;
    logic [9:0]  ball_y;
    logic [9:0]  ball_s;
    logic [9:0]  motion_x;
    logic [9:0]  motion_y;
    logic [1:0]  jstate;
    logic        airborne;

    modport master (
        output key, ball_x, ball_y, ball_s,
        input  motion_x, motion_y, jstate, airborne
    );

    modport slave (
        input  key, ball_x, ball_y, ball_s,
        output motion_x, motion_y, jstate, airborne
    );
endinterface

// File: rtl/jump_motion_ctrl.sv
// Per-frame ball motion sequencer: walk, jump rise, apex hold, fall.
// Stops are exact because motion is computed from the datapath's next position.
module jump_motion_ctrl #(
    parameter int          X_MIN       = 0,
    parameter int          X_MAX       = 639,
    parameter int          Y_MAX       = 479,
    parameter int          STEP        = 1,
    parameter int          JUMP_HEIGHT = 100,
    parameter int          APEX_FRAMES = 4,
    parameter logic [15:0] KEY_UP      = 16'h001A,
    parameter logic [15:0] KEY_LEFT    = 16'h0004,
    parameter logic [15:0] KEY_RIGHT   = 16'h0007
) (
    input logic          frame_clk,
    input logic          Reset,
    jump_motion_if.slave bus
);

    localparam logic [1:0] GROUND = 2'd0;
    localparam logic [1:0] RISE   = 2'd1;
    localparam logic [1:0] APEX   = 2'd2;
    localparam logic [1:0] FALL   = 2'd3;

    localparam logic signed [10:0] ZERO_S = 11'sd0;
    localparam logic signed [10:0] XMIN_S = 11'(X_MIN);
    localparam logic signed [10:0] XMAX_S = 11'(X_MAX);
    localparam logic signed [10:0] YMAX_S = 11'(Y_MAX);
    localparam logic signed [10:0] STEP_S = 11'(STEP);
    localparam logic signed [10:0] JH_S   = 11'(JUMP_HEIGHT);
    localparam logic [7:0]         APEX_INIT = 8'(APEX_FRAMES - 1);

    logic [1:0]         jstate_q;
    logic [1:0]         jstate_d;
    logic [15:0]        prev_key;
    logic [7:0]         apex_cnt_q;
    logic [7:0]         apex_cnt_d;
    logic [9:0]         mx_q;
    logic [9:0]         mx_d;
    logic [9:0]         my_q;
    logic [9:0]         my_d;
    logic signed [10:0] top_q;
    logic signed [10:0] top_d;

    logic signed [10:0] bx;
    logic signed [10:0] by;
    logic signed [10:0] bs;
    logic signed [10:0] px;
    logic signed [10:0] py;
    logic signed [10:0] room_l;
    logic signed [10:0] room_r;
    logic signed [10:0] top_new;
    logic signed [10:0] land_gap;
    logic               jump_edge;

    // Distance limited to [0, STEP]; negative room means no movement.
    function automatic logic signed [10:0] clamp_step(
        input logic signed [10:0] v
    );
        logic signed [10:0] r;
        if (v[10] || v == ZERO_S)
            r = ZERO_S;
        else if (v < STEP_S)
            r = v;
        else
            r = STEP_S;
        return r;
    endfunction

    assign bx = $signed({1'b0, bus.ball_x});
    assign by = $signed({1'b0, bus.ball_y});
    assign bs = $signed({1'b0, bus.ball_s});
    assign px = bx + $signed({mx_q[9], mx_q});
    assign py = by + $signed({my_q[9], my_q});

    always_comb begin
        jump_edge  = (bus.key == KEY_UP) && (prev_key != KEY_UP);
        room_l     = px - bs - XMIN_S;
        room_r     = XMAX_S - bs - px;
        land_gap   = YMAX_S - bs - py;
        top_new    = py - JH_S;
        if (top_new < bs)
            top_new = bs;

        mx_d = '0;
        unique case (1'b1)
            (bus.key == KEY_LEFT):  mx_d = 10'(ZERO_S - clamp_step(room_l));
            (bus.key == KEY_RIGHT): mx_d = 10'(clamp_step(room_r));
            default:                mx_d = '0;
        endcase

        jstate_d   = jstate_q;
        my_d       = '0;
        top_d      = top_q;
        apex_cnt_d = apex_cnt_q;
        unique case (jstate_q)
            GROUND: begin
                if (jump_edge) begin
                    top_d    = top_new;
                    jstate_d = RISE;
                    my_d     = 10'(ZERO_S - clamp_step(py - top_new));
                end
            end
            RISE: begin
                if (py - STEP_S <= top_q) begin
                    my_d       = 10'(top_q - py);
                    jstate_d   = APEX;
                    apex_cnt_d = APEX_INIT;
                end else begin
                    my_d = 10'(ZERO_S - STEP_S);
                end
            end
            APEX: begin
                apex_cnt_d = apex_cnt_q - 8'd1;
                if (apex_cnt_q == '0) begin
                    jstate_d = FALL;
                    my_d     = 10'(STEP_S);
                end
            end
            FALL: begin
                if (py + bs + STEP_S >= YMAX_S) begin
                    jstate_d = GROUND;
                    my_d     = land_gap[10] ? '0 : 10'(land_gap);
                end else begin
                    my_d = 10'(STEP_S);
                end
            end
            default: begin
                jstate_d = FALL;
            end
        endcase
    end

    // Reset into FALL so a ball left mid-air settles onto the floor.
    always_ff @(posedge frame_clk or posedge Reset) begin
        if (Reset) begin
            jstate_q   <= FALL;
            prev_key   <= '0;
            apex_cnt_q <= '0;
            mx_q       <= '0;
            my_q       <= '0;
            top_q      <= '0;
        end else begin
            jstate_q   <= jstate_d;
            prev_key   <= bus.key;
            apex_cnt_q <= apex_cnt_d;
            mx_q       <= mx_d;
            my_q       <= my_d;
            top_q      <= top_d;
        end
    end

    assign bus.motion_x = mx_q;
    assign bus.motion_y = my_q;
    assign bus.jstate   = jstate_q;
    assign bus.airborne = (jstate_q != GROUND);

endmodule

// File: tb/tb_jump_motion_ctrl.sv
// Bench for jump_motion_ctrl: integrates ball position from the motion
// outputs and compares against a frame-level model of the jump rules.
module tb_jump_motion_ctrl;

    logic frame_clk;
    logic Reset;

    jump_motion_if jif ();

    jump_motion_ctrl dut (
        .frame_clk (frame_clk),
        .Reset     (Reset),
        .bus       (jif)
    );

    initial frame_clk = 1'b0;
    always #5 frame_clk = ~frame_clk;

    int passed;
    int total;
    int bx;
    int by;
    int bs;

    int m_mx;
    int m_my;
    int m_ph;
    int m_pk;
    int m_cnt;
    int m_top;

    function automatic int lim(input int v);
        return (v < 0) ? 0 : ((v > 1) ? 1 : v);
    endfunction

    function automatic logic [22:0] expv();
        return {10'(m_mx), 10'(m_my), 2'(m_ph), (m_ph != 0)};
    endfunction

    function automatic logic [22:0] gotv();
        return {jif.motion_x, jif.motion_y, jif.jstate, jif.airborne};
    endfunction

    task automatic model_reset();
        m_mx = 0; m_my = 0; m_ph = 3; m_pk = 0; m_cnt = 0; m_top = 0;
    endtask

    // Frame-level reference: phases 0 ground, 1 rise, 2 apex, 3 fall.
    task automatic model_edge();
        int k, px, py, nmx, nmy, t;
        k   = int'(jif.key);
        px  = bx + m_mx;
        py  = by + m_my;
        nmx = 0;
        if (k == 'h0004) nmx = -lim(px - bs - 0);
        else if (k == 'h0007) nmx = lim(639 - bs - px);
        nmy = 0;
        case (m_ph)
            0: if (k == 'h001A && m_pk != 'h001A) begin
                t = (py - 100 > bs) ? py - 100 : bs;
                m_top = t;
                nmy = -lim(py - t);
                m_ph = 1;
            end
            1: if (py - 1 <= m_top) begin
                nmy = m_top - py; m_ph = 2; m_cnt = 3;
            end else nmy = -1;
            2: begin
                if (m_cnt == 0) begin m_ph = 3; nmy = 1; end
                m_cnt = m_cnt - 1;
            end
            default: if (py + bs + 1 >= 479) begin
                nmy = (479 - bs - py > 0) ? 479 - bs - py : 0;
                m_ph = 0;
            end else nmy = 1;
        endcase
        m_mx = nmx;
        m_my = nmy;
        m_pk = k;
    endtask

    task automatic drive_ball();
        jif.ball_x = 10'(bx);
        jif.ball_y = 10'(by);
        jif.ball_s = 10'(bs);
    endtask

    // One frame: model steps, datapath integrates the DUT's pre-edge motion.
    task automatic tick();
        int omx, omy;
        omx = int'($signed(jif.motion_x));
        omy = int'($signed(jif.motion_y));
        model_edge();
        @(posedge frame_clk);
        #1;
        bx = bx + omx;
        by = by + omy;
        drive_ball();
    endtask

    task automatic test_reset();
        Reset = 1'b1;
        jif.key = '0;
        bx = 320; by = 240; bs = 4;
        drive_ball();
        model_reset();
        repeat (2) @(posedge frame_clk);
        #1;
        total++;
        if (gotv() !== {10'd0, 10'd0, 2'd3, 1'b1})
            $display("FAIL reset_state: got %h want %h", gotv(), {10'd0, 10'd0, 2'd3, 1'b1});
        else passed++;
        Reset = 1'b0;
    endtask

    task automatic test_fall_to_ground();
        int maxy;
        tick();
        total++;
        if (jif.motion_y !== 10'd1 || jif.jstate !== 2'd3)
            $display("FAIL first_fall: got my=%h st=%0d want my=001 st=3", jif.motion_y, jif.jstate);
        else passed++;
        maxy = by;
        for (int i = 0; i < 240; i++) begin
            tick();
            if (by > maxy) maxy = by;
            total++;
            if (gotv() !== expv())
                $display("FAIL fall_model: frame %0d got %h want %h", i, gotv(), expv());
            else passed++;
        end
        total++;
        if (by !== 475 || maxy !== 475 || jif.motion_y !== 10'd0 || jif.jstate !== 2'd0)
            $display("FAIL landing: got y=%0d max=%0d my=%h st=%0d want y=475 max=475 my=000 st=0",
                     by, maxy, jif.motion_y, jif.jstate);
        else passed++;
    endtask

    task automatic test_single_jump();
        int miny, apex_n;
        bit done;
        jif.key = 16'h001A;
        tick();
        jif.key = '0;
        total++;
        if (jif.jstate !== 2'd1 || jif.motion_y !== 10'h3FF)
            $display("FAIL takeoff: got st=%0d my=%h want st=1 my=3ff", jif.jstate, jif.motion_y);
        else passed++;
        miny = by; apex_n = 0; done = 0;
        for (int i = 0; i < 300 && !done; i++) begin
            tick();
            if (by < miny) miny = by;
            if (jif.jstate == 2'd2) apex_n++;
            total++;
            if (gotv() !== expv())
                $display("FAIL jump_model: frame %0d got %h want %h", i, gotv(), expv());
            else passed++;
            if (jif.jstate == 2'd0) done = 1;
        end
        tick();
        total++;
        if (!done || miny !== 375 || apex_n !== 4 || by !== 475)
            $display("FAIL jump_profile: got done=%0d top=%0d apex=%0d y=%0d want 1/375/4/475",
                     done, miny, apex_n, by);
        else passed++;
    endtask

    task automatic test_held_jump();
        int rises;
        logic [1:0] prev;
        bit done;
        rises = 0;
        prev = jif.jstate;
        jif.key = 16'h001A;
        for (int i = 0; i < 240; i++) begin
            tick();
            if (jif.jstate == 2'd1 && prev != 2'd1) rises++;
            prev = jif.jstate;
            total++;
            if (gotv() !== expv())
                $display("FAIL held_model: frame %0d got %h want %h", i, gotv(), expv());
            else passed++;
        end
        total++;
        if (rises !== 1 || jif.jstate !== 2'd0 || by !== 475)
            $display("FAIL held_once: got rises=%0d st=%0d y=%0d want 1/0/475", rises, jif.jstate, by);
        else passed++;
        jif.key = '0;
        tick();
        jif.key = 16'h001A;
        tick();
        jif.key = '0;
        total++;
        if (jif.jstate !== 2'd1)
            $display("FAIL repress: got st=%0d want 1", jif.jstate);
        else passed++;
        done = 0;
        for (int i = 0; i < 300 && !done; i++) begin
            tick();
            if (jif.jstate == 2'd0) done = 1;
        end
        tick();
        total++;
        if (!done || by !== 475)
            $display("FAIL repress_land: got done=%0d y=%0d want 1/475", done, by);
        else passed++;
    endtask

    task automatic test_walls();
        int lseq[5];
        int rseq[5];
        lseq = '{6, 5, 4, 4, 4};
        rseq = '{633, 634, 635, 635, 635};
        bx = 6; drive_ball();
        jif.key = 16'h0004;
        for (int i = 0; i < 5; i++) begin
            tick();
            total++;
            if (bx !== lseq[i] || gotv() !== expv())
                $display("FAIL left_wall: step %0d got x=%0d v=%h want x=%0d v=%h",
                         i, bx, gotv(), lseq[i], expv());
            else passed++;
        end
        jif.key = '0;
        tick();
        bx = 633; drive_ball();
        jif.key = 16'h0007;
        for (int i = 0; i < 5; i++) begin
            tick();
            total++;
            if (bx !== rseq[i] || gotv() !== expv())
                $display("FAIL right_wall: step %0d got x=%0d v=%h want x=%0d v=%h",
                         i, bx, gotv(), rseq[i], expv());
            else passed++;
        end
        jif.key = '0;
        tick();
    endtask

    task automatic test_ceiling_clamp();
        int miny;
        bit done;
        by = 50; drive_ball();
        jif.key = 16'h001A;
        tick();
        jif.key = '0;
        miny = by; done = 0;
        for (int i = 0; i < 200 && !done; i++) begin
            tick();
            if (by < miny) miny = by;
            total++;
            if (gotv() !== expv())
                $display("FAIL ceil_model: frame %0d got %h want %h", i, gotv(), expv());
            else passed++;
            if (jif.jstate == 2'd3) done = 1;
        end
        total++;
        if (!done || miny !== 4)
            $display("FAIL ceil_clamp: got done=%0d top=%0d want 1/4", done, miny);
        else passed++;
        done = 0;
        for (int i = 0; i < 600 && !done; i++) begin
            tick();
            if (jif.jstate == 2'd0) done = 1;
        end
        tick();
        total++;
        if (!done || by !== 475)
            $display("FAIL ceil_land: got done=%0d y=%0d want 1/475", done, by);
        else passed++;
    endtask

    task automatic test_reset_midair();
        bit done;
        jif.key = 16'h001A;
        tick();
        jif.key = '0;
        done = 0;
        for (int i = 0; i < 200 && !done; i++) begin
            tick();
            if (by == 420) done = 1;
        end
        total++;
        if (!done || jif.jstate !== 2'd1)
            $display("FAIL reach_420: got done=%0d st=%0d want 1/1", done, jif.jstate);
        else passed++;
        #3;
        Reset = 1'b1;
        #1;
        model_reset();
        total++;
        if (gotv() !== {10'd0, 10'd0, 2'd3, 1'b1})
            $display("FAIL async_reset: got %h want %h", gotv(), {10'd0, 10'd0, 2'd3, 1'b1});
        else passed++;
        repeat (2) @(posedge frame_clk);
        #1;
        Reset = 1'b0;
        done = 0;
        for (int i = 0; i < 200 && !done; i++) begin
            tick();
            total++;
            if (gotv() !== expv())
                $display("FAIL refall_model: frame %0d got %h want %h", i, gotv(), expv());
            else passed++;
            if (jif.jstate == 2'd0) done = 1;
        end
        tick();
        total++;
        if (!done || by !== 475)
            $display("FAIL refall_land: got done=%0d y=%0d want 1/475", done, by);
        else passed++;
    endtask

    task automatic test_random();
        int hold, r;
        logic [15:0] k;
        k = '0;
        hold = 0;
        for (int i = 0; i < 1500; i++) begin
            if (hold == 0) begin
                r = int'($urandom_range(0, 7));
                case (r)
                    0, 1:    k = '0;
                    2, 3:    k = 16'h001A;
                    4, 5:    k = 16'h0004;
                    6:       k = 16'h0007;
                    default: k = 16'($urandom);
                endcase
                hold = int'($urandom_range(1, 20));
            end
            hold--;
            jif.key = k;
            tick();
            total++;
            if (gotv() !== expv())
                $display("FAIL random_model: frame %0d key %h got %h want %h", i, k, gotv(), expv());
            else passed++;
        end
        jif.key = '0;
    endtask

    initial begin
        passed = 0;
        total  = 0;
        test_reset();
        test_fall_to_ground();
        test_single_jump();
        test_held_jump();
        test_walls();
        test_ceiling_clamp();
        test_reset_midair();
        test_random();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
